ext_mem_bank: RTL and testbench



---
 rtl/ext_mem_bank.sv | 138 +++++++++++++
 tb/tb_ext_mem_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_bank.sv
// Multi-channel external memory slave for the regslv ext_* port bundle.
// Define EXT_MEM_BANK_ERR_EN to add the per-channel ack_err output.
//
// state | meaning
// IDLE  | ready, req_rdy high once out of reset
// BUSY  | latency down-counter running; memory access at terminal count
// ACK   | ack_vld high, rd_data held until shared ack_rdy
module ext_mem_bank #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 6,
    parameter int unsigned CH_NUM         = 3,
    parameter logic [63:0] BASE_ADDR      = 64'h200,
    parameter logic [63:0] CH_STRIDE      = 64'h100,
    parameter int unsigned RD_LATENCY     = 2,
    parameter int unsigned WR_LATENCY     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_NUM-1:0]            req_vld,
    output logic [CH_NUM-1:0]            req_rdy,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic [CH_NUM-1:0]            ack_vld,
    input  logic                         ack_rdy,
`ifdef EXT_MEM_BANK_ERR_EN
    output logic [CH_NUM-1:0]            ack_err,
`endif
    output logic [CH_NUM*DATA_WIDTH-1:0] rd_data
);
    localparam int unsigned B     = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WIN   = MEM_ADDR_WIDTH + B;
    localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_e;

    // Holds req_rdy low until the first edge after reset release.
    logic init_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) init_q <= 1'b0;
        else     init_q <= 1'b1;
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        localparam logic [ADDR_WIDTH-1:0] CH_BASE =
            ADDR_WIDTH'(BASE_ADDR + CH_STRIDE * 64'(g));

        state_e                    state_q, state_d;
        logic [3:0]                cnt_q, cnt_d;
        logic                      is_wr_q, is_wr_d;
        logic                      is_rd_q, is_rd_d;
        logic                      ok_q, ok_d;
        logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
        logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
        logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
        logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
        logic [ADDR_WIDTH-1:0]     local_a;
        logic                      accept;
        logic                      commit;

        assign local_a = addr - CH_BASE;
        assign accept  = req_vld[g] & req_rdy[g];
        assign commit  = (state_q == S_BUSY) && (cnt_q == 4'd0);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            is_wr_d = is_wr_q;
            is_rd_d = is_rd_q;
            ok_d    = ok_q;
            idx_d   = idx_q;
            wdata_d = wdata_q;
            rdata_d = rdata_q;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        is_wr_d = wr_en & ~rd_en;
                        is_rd_d = rd_en & ~wr_en;
                        ok_d    = (addr >= CH_BASE) && ((local_a >> WIN) == '0);
                        idx_d   = MEM_ADDR_WIDTH'(local_a >> B);
                        wdata_d = wr_data;
                        cnt_d   = is_rd_d ? 4'(RD_LATENCY) : 4'(WR_LATENCY);
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        rdata_d = (is_rd_q && ok_q) ? mem_q[idx_q] : '0;
                        state_d = S_ACK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    if (ack_rdy) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                is_wr_q <= 1'b0;
                is_rd_q <= 1'b0;
                ok_q    <= 1'b0;
                idx_q   <= '0;
                wdata_q <= '0;
                rdata_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                is_wr_q <= is_wr_d;
                is_rd_q <= is_rd_d;
                ok_q    <= ok_d;
                idx_q   <= idx_d;
                wdata_q <= wdata_d;
                rdata_q <= rdata_d;
            end
        end

        // Array is not reset; a reset during BUSY leaves state_q in IDLE so the write is dropped.
        always_ff @(posedge clk) begin
            if (commit && is_wr_q && ok_q) mem_q[idx_q] <= wdata_q;
        end

        assign req_rdy[g] = init_q && (state_q == S_IDLE);
        assign ack_vld[g] = (state_q == S_ACK);
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
`ifdef EXT_MEM_BANK_ERR_EN
        assign ack_err[g] = (state_q == S_ACK) && !((is_wr_q || is_rd_q) && ok_q);
`endif
    end
endmodule

// File: tb/tb_ext_mem_bank.sv
// Self-checking bench for ext_mem_bank: directed scenarios plus randomized rounds
// checked against an array model of the per-channel memories and latency rules.
module tb_ext_mem_bank;
    localparam int DW = 32;
    localparam int CH = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   req_vld, req_rdy, ack_vld;
    logic            wr_en, rd_en, ack_rdy;
    logic [63:0]     addr;
    logic [DW-1:0]   wr_data;
    logic [CH*DW-1:0] rd_data;
`ifdef EXT_MEM_BANK_ERR_EN
    logic [CH-1:0]   ack_err;
`endif

    ext_mem_bank dut (
        .clk    (clk),
        .rst    (rst),
        .req_vld(req_vld),
        .req_rdy(req_rdy),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wr_data(wr_data),
        .ack_vld(ack_vld),
        .ack_rdy(ack_rdy),
`ifdef EXT_MEM_BANK_ERR_EN
        .ack_err(ack_err),
`endif
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    logic [DW-1:0] ref_mem [CH][64];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // op: 0 write, 1 read, 2 both enables set, 3 neither set
    int            r_n;
    int            r_hold;
    int            r_ch [3];
    int            r_op [3];
    logic [63:0]   r_addr [3];
    logic [DW-1:0] r_data [3];

    task automatic set_slot(input int s, input int c, input int op, input logic [63:0] a,
                            input logic [DW-1:0] d);
        r_ch[s] = c; r_op[s] = op; r_addr[s] = a; r_data[s] = d;
    endtask

    // Issues r_n requests on distinct channels on consecutive edges, then checks
    // ack timing, held data and the shared ack_rdy handshake.
    task automatic run_round();
        int            due [3];
        int            idx [3];
        logic [DW-1:0] exp_d [3];
        logic          exp_e [3];
        logic          do_wr [3];
        int            maxdue, fin, c;
        longint        loc;
        logic          inwin, exp_v;
        maxdue = 0;
        for (int s = 0; s < r_n; s++) begin
            @(negedge clk);
            c = r_ch[s];
            check_val("req_rdy_idle", 64'(req_rdy[c]), 64'd1);
            req_vld    = '0;
            req_vld[c] = 1'b1;
            wr_en   = (r_op[s] == 0 || r_op[s] == 2);
            rd_en   = (r_op[s] == 1 || r_op[s] == 2);
            addr    = r_addr[s];
            wr_data = r_data[s];
            loc      = longint'(r_addr[s]) - longint'(64'h200 + 64'h100 * c);
            inwin    = (loc >= 0) && (loc < 256);
            idx[s]   = inwin ? int'(loc / 4) : 0;
            do_wr[s] = inwin && (r_op[s] == 0);
            exp_d[s] = (inwin && r_op[s] == 1) ? ref_mem[c][idx[s]] : '0;
            exp_e[s] = !(inwin && r_op[s] < 2);
            due[s]   = edge_n + 1 + ((r_op[s] == 1) ? 2 : 1) + 1;
            if (due[s] > maxdue) maxdue = due[s];
        end
        @(negedge clk);
        req_vld = '0;
        wr_en   = 1'($urandom);
        rd_en   = 1'($urandom);
        addr    = {$urandom, $urandom};
        wr_data = $urandom;
        fin = maxdue + ((r_hold >= 0) ? r_hold : int'($urandom_range(0, 3)));
        while (edge_n <= fin) begin
            for (int s = 0; s < r_n; s++) begin
                c = r_ch[s];
                exp_v = (edge_n >= due[s]);
                check_val("ack_vld", 64'(ack_vld[c]), 64'(exp_v));
                check_val("req_rdy_busy", 64'(req_rdy[c]), 64'd0);
                if (exp_v) check_val("rd_data", 64'(rd_data[c*DW +: DW]), 64'(exp_d[s]));
`ifdef EXT_MEM_BANK_ERR_EN
                check_val("ack_err", 64'(ack_err[c]), 64'(exp_v & exp_e[s]));
`endif
            end
            if (edge_n == fin) ack_rdy = 1'b1;
            @(negedge clk);
        end
        ack_rdy = 1'b0;
        for (int s = 0; s < r_n; s++) begin
            check_val("ack_drop", 64'(ack_vld[r_ch[s]]), 64'd0);
            check_val("req_rdy_back", 64'(req_rdy[r_ch[s]]), 64'd1);
            if (do_wr[s]) ref_mem[r_ch[s]][idx[s]] = r_data[s];
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int perm [3];
        int j, tmp, k, op;
        logic [63:0] a;
        rst = 1'b1; req_vld = '0; wr_en = 1'b0; rd_en = 1'b0; ack_rdy = 1'b0;
        addr = '0; wr_data = '0; r_hold = -1;
        repeat (3) @(negedge clk);
        check_val("rst_req_rdy", 64'(req_rdy), 64'd0);
        check_val("rst_ack_vld", 64'(ack_vld), 64'd0);
        check_val("rst_rd_data", 64'(rd_data[63:0]) | 64'(rd_data[95:64]), 64'd0);
        rst = 1'b0;
        #1 check_val("rel_req_rdy_low", 64'(req_rdy), 64'd0);
        @(negedge clk);
        check_val("rel_req_rdy_high", 64'(req_rdy), 64'h7);

        // Fill every word so later reads have known contents.
        for (int w = 0; w < 64; w++) begin
            r_n = 3;
            for (int s = 0; s < 3; s++)
                set_slot(s, s, 0, 64'h200 + 64'h100 * s + 64'(4 * w), $urandom);
            run_round();
        end

        r_n = 1;
        set_slot(0, 1, 0, 64'h300, 32'hFFFF_FFFF); run_round();
        set_slot(0, 1, 1, 64'h300, 32'h0);         run_round();

        set_slot(0, 0, 0, 64'h204, 32'hA5A5_0001); run_round();
        r_hold = 5;
        set_slot(0, 0, 1, 64'h204, 32'h0);         run_round();
        r_hold = -1;

        r_n = 2;
        set_slot(0, 0, 0, 64'h200, 32'h1234_5678);
        set_slot(1, 2, 0, 64'h4FC, 32'h8765_4321); run_round();
        r_n = 3;
        set_slot(0, 0, 1, 64'h200, 32'h0);
        set_slot(1, 2, 1, 64'h4FC, 32'h0);
        set_slot(2, 1, 1, 64'h300, 32'h0);         run_round();

        r_n = 1;
        set_slot(0, 2, 0, 64'h4FC, 32'hCAFE_F00D); run_round();
        set_slot(0, 2, 0, 64'h500, 32'hBAD0_BAD0); run_round();
        set_slot(0, 2, 1, 64'h500, 32'h0);         run_round();
        set_slot(0, 2, 1, 64'h4FC, 32'h0);         run_round();
        set_slot(0, 0, 1, 64'h1FC, 32'h0);         run_round();

        set_slot(0, 0, 2, 64'h200, 32'hDEAD_0000); run_round();
        set_slot(0, 0, 3, 64'h200, 32'hDEAD_0001); run_round();
        set_slot(0, 0, 1, 64'h200, 32'h0);         run_round();

        // Reset while ch0 sits in ACK and ch1 is still counting down on a write.
        @(negedge clk);
        req_vld = 3'b001; wr_en = 1'b1; rd_en = 1'b0; addr = 64'h208; wr_data = 32'h1111_2222;
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        req_vld = 3'b010; addr = 64'h310; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        req_vld = '0;
        check_val("pre_rst_ack0", 64'(ack_vld[0]), 64'd1);
        check_val("pre_rst_busy1", 64'(ack_vld[1]), 64'd0);
        rst = 1'b1;
        #1;
        check_val("mid_rst_ack_vld", 64'(ack_vld), 64'd0);
        check_val("mid_rst_req_rdy", 64'(req_rdy), 64'd0);
        ref_mem[0][2] = 32'h1111_2222;
        @(negedge clk);
        rst = 1'b0;
        #1 check_val("mid_rel_req_rdy_low", 64'(req_rdy), 64'd0);
        @(negedge clk);
        check_val("mid_rel_req_rdy_high", 64'(req_rdy), 64'h7);
        r_n = 2;
        set_slot(0, 1, 1, 64'h310, 32'h0);
        set_slot(1, 0, 1, 64'h208, 32'h0);         run_round();

        for (int r = 0; r < 150; r++) begin
            perm[0] = 0; perm[1] = 1; perm[2] = 2;
            for (int i = 2; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            r_n = int'($urandom_range(1, 3));
            for (int s = 0; s < r_n; s++) begin
                k = int'($urandom_range(0, 19));
                op = (k < 9) ? 0 : (k < 18) ? 1 : (k == 18) ? 2 : 3;
                if ($urandom_range(0, 6) != 0)
                    a = 64'h200 + 64'h100 * perm[s] + 64'($urandom_range(0, 255));
                else
                    a = 64'($urandom_range(0, 32'h7FF));
                set_slot(s, perm[s], op, a, $urandom);
            end
            run_round();
        end

        for (int w = 0; w < 64; w++) begin
            r_n = 3;
            for (int s = 0; s < 3; s++)
                set_slot(s, s, 1, 64'h200 + 64'h100 * s + 64'(4 * w), 32'h0);
            run_round();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
